// File: rtl/br_update_arb_pkg.sv
// Shared branch-prediction types and default sizes.
//   BrInstType_t : control-flow instruction class
//   BrUpdate_t   : one update record at the default address width
package br_update_arb_pkg;

  typedef enum logic [1:0] {
    BR_BRANCH,
    BR_JUMP,
    BR_CALL,
    BR_RETURN
  } BrInstType_t;

  localparam int unsigned BrAddrW   = 32;
  localparam int unsigned BtbDepth  = 512;
  localparam int unsigned UpdqDepth = 4;
  localparam int unsigned StarveLim = 3;

  typedef struct packed {
    BrInstType_t        btype;
    logic               taken;
    logic               miss;
    logic [BrAddrW-1:0] pc;
    logic [BrAddrW-1:0] tar;
  } BrUpdate_t;

endpackage

// File: rtl/br_update_arb_if.sv
// Bundle of commit, decode-insert and update-port signals for br_update_arb.
//   slave  : the arbiter (consumes com_*/dec_*/flush, produces upd_*, stalls, acks)
//   master : the surrounding pipeline / predictor side
interface br_update_arb_if import br_update_arb_pkg::*; #(
  parameter int unsigned ADDR  = 32,
  parameter int unsigned IDX_W = 9
) ();

  logic              com_valid;
  BrInstType_t       com_type;
  logic              com_taken;
  logic              com_miss;
  logic [ADDR-1:0]   com_pc;
  logic [ADDR-1:0]   com_tar;
  logic              com_stall;

  logic              dec_ins_req;
  BrInstType_t       dec_ins_type;
  logic [ADDR-1:0]   dec_ins_pc;
  logic [ADDR-1:0]   dec_ins_tar;
  logic              dec_ins_ack;

  logic              flush;

  logic              upd_valid;
  logic              upd_inval;
  logic [IDX_W-1:0]  upd_idx;
  logic [ADDR-1:0]   upd_pc;
  logic [ADDR-1:0]   upd_tar;
  BrInstType_t       upd_type;
  logic              upd_taken;
  logic              upd_miss;
  logic              upd_pred_en;
  logic              init_done;

  modport slave (
    input  com_valid, com_type, com_taken, com_miss, com_pc, com_tar,
    input  dec_ins_req, dec_ins_type, dec_ins_pc, dec_ins_tar, flush,
    output com_stall, dec_ins_ack,
    output upd_valid, upd_inval, upd_idx, upd_pc, upd_tar, upd_type,
    output upd_taken, upd_miss, upd_pred_en, init_done
  );

  modport master (
    output com_valid, com_type, com_taken, com_miss, com_pc, com_tar,
    output dec_ins_req, dec_ins_type, dec_ins_pc, dec_ins_tar, flush,
    input  com_stall, dec_ins_ack,
    input  upd_valid, upd_inval, upd_idx, upd_pc, upd_tar, upd_type,
    input  upd_taken, upd_miss, upd_pred_en, init_done
  );

endinterface

// File: rtl/br_upd_fifo.sv
// Synchronous FIFO for committed branch updates.
//   clk_i, rst_i      : clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   : write; ignored when full unless a pop happens the same cycle
//   pop_i, rdata_o    : head entry is shown combinationally, pop advances it
//   full_o, empty_o   : registered occupancy flags
// Depth must be a power of two >= 2; pointers carry one extra MSB for full/empty.
module br_upd_fifo import br_update_arb_pkg::*; #(
  parameter int unsigned Depth = UpdqDepth,
  parameter type         T     = BrUpdate_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  T             mem_q [Depth];
  logic [Aw:0]  wptr_q, wptr_d;
  logic [Aw:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[Aw-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/br_update_arb.sv
// Single write port into the branch-prediction structures.
//   clk, reset : clock, synchronous active-high reset
//   bus        : br_update_arb_if.slave -- commit input (com_*), decode BTB insert
//                (dec_ins_*), flush, and the update port (upd_*, init_done)
// After reset every BTB index is invalidated once; then committed updates (buffered)
// and decode inserts share the port, with a starvation limit protecting decode.
// Optional: define BR_UPD_BYPASS_EN to let a commit hitting an empty FIFO be
// granted in the same cycle instead of being queued.
module br_update_arb import br_update_arb_pkg::*; #(
  parameter int unsigned ADDR       = BrAddrW,
  parameter int unsigned BTB_DEPTH  = BtbDepth,
  parameter int unsigned UPDQ_DEPTH = UpdqDepth,
  parameter int unsigned STARVE_LIM = StarveLim,
  parameter int unsigned BTB_IDX    = $clog2(BTB_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  br_update_arb_if.slave bus
);

  typedef struct packed {
    BrInstType_t     btype;
    logic            taken;
    logic            miss;
    logic [ADDR-1:0] pc;
    logic [ADDR-1:0] tar;
  } entry_t;

  typedef enum logic {StInit, StRun} state_e;

  localparam int unsigned        StarveW   = $clog2(STARVE_LIM + 1) > 0 ?
                                             $clog2(STARVE_LIM + 1) : 1;
  localparam logic [BTB_IDX-1:0] SweepLast = BTB_IDX'(BTB_DEPTH - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIM);

  state_e               state_q, state_d;
  logic [BTB_IDX-1:0]   sweep_q, sweep_d;
  logic [StarveW-1:0]   starve_q, starve_d;

  entry_t com_entry, head, sel;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic   bypass, dec_forced;

  assign com_entry = '{btype: bus.com_type, taken: bus.com_taken, miss: bus.com_miss,
                       pc: bus.com_pc, tar: bus.com_tar};

  br_upd_fifo #(
    .Depth (UPDQ_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i (com_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    starve_d        = starve_q;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;
    sel             = head;
    bypass          = 1'b0;
    dec_forced      = 1'b0;
    bus.com_stall   = 1'b1;
    bus.dec_ins_ack = 1'b0;
    bus.upd_valid   = 1'b0;
    bus.upd_inval   = 1'b0;
    bus.upd_idx     = '0;
    bus.upd_pc      = '0;
    bus.upd_tar     = '0;
    bus.upd_type    = BR_BRANCH;
    bus.upd_taken   = 1'b0;
    bus.upd_miss    = 1'b0;
    bus.upd_pred_en = 1'b0;
    bus.init_done   = 1'b0;

    // Outputs hold their reset values while reset is asserted.
    if (!reset) begin
      unique case (state_q)
        StInit: begin
          bus.upd_valid = 1'b1;
          bus.upd_inval = 1'b1;
          bus.upd_idx   = sweep_q;
          sweep_d       = sweep_q + 1'b1;
          if (sweep_q == SweepLast) begin
            state_d       = StRun;
            bus.init_done = 1'b1;
          end
        end

        StRun: begin
          bus.init_done = 1'b1;
          bus.com_stall = fifo_full;
          dec_forced    = bus.dec_ins_req && (starve_q == StarveMax);
`ifdef BR_UPD_BYPASS_EN
          bypass        = fifo_empty && bus.com_valid;
`endif
          fifo_push     = bus.com_valid && !fifo_full;

          if ((!fifo_empty || bypass) && !dec_forced) begin
            fifo_pop  = !fifo_empty;
            sel       = fifo_empty ? com_entry : head;
            // A bypassed commit is consumed directly and never queued.
            if (fifo_empty) fifo_push = 1'b0;
            bus.upd_valid   = 1'b1;
            bus.upd_pc      = sel.pc;
            bus.upd_tar     = sel.tar;
            bus.upd_type    = sel.btype;
            bus.upd_taken   = sel.taken;
            bus.upd_miss    = sel.miss;
            bus.upd_pred_en = (sel.btype == BR_BRANCH);
            starve_d        = bus.dec_ins_req ? starve_q + 1'b1 : '0;
          end else if (bus.dec_ins_req && !bus.flush) begin
            bus.dec_ins_ack = 1'b1;
            bus.upd_valid   = 1'b1;
            bus.upd_pc      = bus.dec_ins_pc;
            bus.upd_tar     = bus.dec_ins_tar;
            bus.upd_type    = bus.dec_ins_type;
            bus.upd_taken   = 1'b1;
            starve_d        = '0;
          end

          if (bus.flush) starve_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      sweep_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_br_update_arb.sv
// Directed bench for br_update_arb (BTB_DEPTH=8, UPDQ_DEPTH=4, STARVE_LIM=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_br_update_arb;
  import br_update_arb_pkg::*;

  localparam int unsigned ADDR       = 32;
  localparam int unsigned BTB_DEPTH  = 8;
  localparam int unsigned UPDQ_DEPTH = 4;
  localparam int unsigned STARVE_LIM = 3;
  localparam int unsigned BTB_IDX    = $clog2(BTB_DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  br_update_arb_if #(.ADDR(ADDR), .IDX_W(BTB_IDX)) bif ();

  br_update_arb #(
    .ADDR       (ADDR),
    .BTB_DEPTH  (BTB_DEPTH),
    .UPDQ_DEPTH (UPDQ_DEPTH),
    .STARVE_LIM (STARVE_LIM),
    .BTB_IDX    (BTB_IDX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int errors = 0;
  int checks = 0;
  int k;

  // Expected grant per stream cycle: commit index, or -1 for a decode insert.
  int exp_g [17] = '{-1, 0, 1, 2, -1, 3, 4, 5, -1, 6, 7, 8, -1, 9, 10, 11, -1};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cpc(input int n);
    return 32'h1000 + 32'(n * 16);
  endfunction

  task automatic drive_com(input int n);
    bif.com_valid = 1'b1;
    bif.com_pc    = cpc(n);
    bif.com_tar   = cpc(n) + 32'h40;
    bif.com_type  = (n % 2 == 0) ? BR_BRANCH : BR_JUMP;
    bif.com_taken = (n % 2 == 0);
    bif.com_miss  = 1'b0;
  endtask

  task automatic sweep_checks();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1("sweep_valid", bif.upd_valid, 1'b1);
      chk1("sweep_inval", bif.upd_inval, 1'b1);
      chkw("sweep_idx", 32'(bif.upd_idx), 32'(i));
      chk1("sweep_done", bif.init_done, i == 7);
      chk1("sweep_stall", bif.com_stall, 1'b1);
      chk1("sweep_ack", bif.dec_ins_ack, 1'b0);
      tick();
    end
  endtask

  initial begin
    bif.com_valid    = 1'b0;
    bif.com_type     = BR_BRANCH;
    bif.com_taken    = 1'b0;
    bif.com_miss     = 1'b0;
    bif.com_pc       = '0;
    bif.com_tar      = '0;
    bif.dec_ins_req  = 1'b0;
    bif.dec_ins_type = BR_CALL;
    bif.dec_ins_pc   = 32'h3000;
    bif.dec_ins_tar  = 32'h3400;
    bif.flush        = 1'b0;

    // Reset held for two edges.
    tick();
    #1;
    chk1("rst_valid", bif.upd_valid, 1'b0);
    chk1("rst_stall", bif.com_stall, 1'b1);
    chk1("rst_done", bif.init_done, 1'b0);
    chk1("rst_inval", bif.upd_inval, 1'b0);
    tick();
    reset = 1'b0;

    // Init sweep over 8 entries.
    sweep_checks();
    #1;
    chk1("run_stall", bif.com_stall, 1'b0);
    chk1("run_done", bif.init_done, 1'b1);
    chk1("run_idle", bif.upd_valid, 1'b0);

    // Basic commit: visible the cycle after the push.
    bif.com_valid = 1'b1;
    bif.com_type  = BR_BRANCH;
    bif.com_taken = 1'b1;
    bif.com_miss  = 1'b1;
    bif.com_pc    = 32'h100;
    bif.com_tar   = 32'h180;
    #1;
    chk1("basic_lat", bif.upd_valid, 1'b0);
    tick();
    bif.com_valid = 1'b0;
    #1;
    chk1("basic_valid", bif.upd_valid, 1'b1);
    chk1("basic_inval", bif.upd_inval, 1'b0);
    chkw("basic_pc", bif.upd_pc, 32'h100);
    chkw("basic_tar", bif.upd_tar, 32'h180);
    chkw("basic_type", 32'(bif.upd_type), 32'(BR_BRANCH));
    chk1("basic_taken", bif.upd_taken, 1'b1);
    chk1("basic_miss", bif.upd_miss, 1'b1);
    chk1("basic_pred", bif.upd_pred_en, 1'b1);
    tick();
    #1;
    chk1("basic_drained", bif.upd_valid, 1'b0);

    // Streaming commits with decode request held: starvation and FIFO fill.
    bif.dec_ins_req = 1'b1;
    k = 0;
    for (int c = 0; c < 17; c++) begin
      drive_com(k);
      #1;
      chk1("stream_stall", bif.com_stall, c == 13);
      chk1("stream_valid", bif.upd_valid, 1'b1);
      if (exp_g[c] < 0) begin
        chk1("stream_dec_ack", bif.dec_ins_ack, 1'b1);
        chkw("stream_dec_pc", bif.upd_pc, 32'h3000);
        chkw("stream_dec_tar", bif.upd_tar, 32'h3400);
        chk1("stream_dec_taken", bif.upd_taken, 1'b1);
        chk1("stream_dec_pred", bif.upd_pred_en, 1'b0);
      end else begin
        chk1("stream_com_ack", bif.dec_ins_ack, 1'b0);
        chkw("stream_com_pc", bif.upd_pc, cpc(exp_g[c]));
        chkw("stream_com_tar", bif.upd_tar, cpc(exp_g[c]) + 32'h40);
        chk1("stream_com_pred", bif.upd_pred_en, exp_g[c] % 2 == 0);
      end
      tick();
      if (c != 13) k++;
    end

    // Drain the four remaining entries in order.
    bif.com_valid   = 1'b0;
    bif.dec_ins_req = 1'b0;
    for (int j = 12; j < 16; j++) begin
      #1;
      chk1("drain_stall", bif.com_stall, j == 12);
      chk1("drain_valid", bif.upd_valid, 1'b1);
      chkw("drain_pc", bif.upd_pc, cpc(j));
      chk1("drain_ack", bif.dec_ins_ack, 1'b0);
      tick();
    end
    #1;
    chk1("drain_empty", bif.upd_valid, 1'b0);

    // Flush suppresses the decode ack for that cycle only.
    bif.dec_ins_req = 1'b1;
    bif.flush       = 1'b1;
    #1;
    chk1("flush_ack", bif.dec_ins_ack, 1'b0);
    chk1("flush_valid", bif.upd_valid, 1'b0);
    tick();
    bif.flush = 1'b0;
    #1;
    chk1("post_flush_ack", bif.dec_ins_ack, 1'b1);
    chkw("post_flush_pc", bif.upd_pc, 32'h3000);
    chk1("post_flush_pred", bif.upd_pred_en, 1'b0);
    tick();

    // Build two queued entries, then reset mid-operation.
    for (int c = 0; c < 5; c++) begin
      drive_com(c);
      tick();
    end
    bif.com_valid   = 1'b0;
    bif.dec_ins_req = 1'b0;
    reset           = 1'b1;
    #1;
    chk1("mid_rst_valid", bif.upd_valid, 1'b0);
    chk1("mid_rst_stall", bif.com_stall, 1'b1);
    chk1("mid_rst_done", bif.init_done, 1'b0);
    tick();
    reset = 1'b0;
    sweep_checks();
    #1;
    chk1("mid_rst_run", bif.init_done, 1'b1);
    chk1("mid_rst_stale0", bif.upd_valid, 1'b0);
    chk1("mid_rst_stall_lo", bif.com_stall, 1'b0);
    tick();
    #1;
    chk1("mid_rst_stale1", bif.upd_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/br_update_arb.md
Name: br_update_arb

Overview:
- Sequences all writes into the branch-prediction structures (BTB, direction predictor, RA stack recovery) through one update port.
- Arbitrates between two requesters:
  - committed branch/jump results, buffered in a small FIFO;
  - decode-time BTB insertions for control-flow instructions that missed the BTB.
- After reset, sweeps every BTB entry to invalid before accepting traffic.
- Sits between the commit/decode stages and the fetch address generator's prediction structures.

Parameters:
- ADDR, 32, address width.
- BTB_DEPTH, 512, number of BTB entries swept at init.
- UPDQ_DEPTH, 4, commit-update FIFO depth (power of 2).
- STARVE_LIM, 3, consecutive commit grants after which a waiting decode insert wins.
- BTB_IDX, $clog2(BTB_DEPTH), derived index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- com_valid  in  1  committed control-flow instruction this cycle.
- com_type  in  BrInstType_t  branch/call/return/jump.
- com_taken  in  1  resolved direction.
- com_miss  in  1  prediction or target mispredicted.
- com_pc  in  ADDR  instruction PC.
- com_tar  in  ADDR  resolved target.
- com_stall  out  1  FIFO full; commit must hold.
- dec_ins_req  in  1  decode insertion request (level, held until ack).
- dec_ins_type  in  BrInstType_t  type.
- dec_ins_pc  in  ADDR  PC.
- dec_ins_tar  in  ADDR  target.
- dec_ins_ack  out  1  insertion accepted this cycle.
- flush  in  1  pipeline flush.
- upd_valid  out  1  update strobe.
- upd_inval  out  1  update is an invalidate (init sweep).
- upd_idx  out  BTB_IDX  index, valid only when upd_inval=1.
- upd_pc  out  ADDR  update PC.
- upd_tar  out  ADDR  update target.
- upd_type  out  BrInstType_t  update type.
- upd_taken  out  1  direction, for the predictor.
- upd_miss  out  1  mispredict flag.
- upd_pred_en  out  1  predictor must train; set only for commit-sourced branches.
- init_done  out  1  sweep complete.

Behaviour:
- **Reset values:** all outputs 0 except com_stall=1. State=INIT, sweep counter=0, FIFO empty, starve counter=0.
- **INIT state:**
  - upd_valid=1, upd_inval=1, upd_idx=counter each cycle.
  - Counter increments each cycle.
  - When counter==BTB_DEPTH-1, the next state is RUN and init_done=1 from that cycle on.
  - com_stall=1 and dec_ins_ack=0 throughout INIT.
- **RUN state:**
  - FIFO push when com_valid && !com_stall.
  - com_stall = FIFO full.
  - Push and pop in the same cycle are allowed when the FIFO is full; stall still reflects registered fullness.
- **Grant rule, each cycle in RUN:**
  - FIFO non-empty, and not (dec_ins_req && starve==STARVE_LIM): pop FIFO, drive its entry on upd_*; upd_pred_en=1 iff type==branch; starve++ if dec_ins_req, else starve=0.
  - Otherwise, if dec_ins_req && !flush: dec_ins_ack=1, drive insert on upd_*, upd_taken=1, upd_miss=0, upd_pred_en=0, starve=0.
  - Otherwise upd_valid=0.
- **Latency:** a commit entry appears on upd_* no earlier than the cycle after push. All update outputs are combinational from FIFO head / arb decision.
- **Flush:** suppresses decode ack in the flush cycle only. FIFO contents are committed state and are never dropped. starve resets to 0.
- **Reset asserted mid-operation:** returns to INIT, restarts the sweep from index 0, and discards the FIFO.
- **Counter widths:** pointer arithmetic wraps modulo UPDQ_DEPTH, with an extra MSB to distinguish full from empty. The sweep counter is BTB_IDX bits.

Optional Feature:
- Macro: BR_UPD_BYPASS_EN.
- When defined: if the FIFO is empty and com_valid in RUN, the commit entry is granted the same cycle without being pushed. Zero latency. Starvation rule unchanged; if the decode insert wins, the entry is pushed normally.
- When undefined: minimum one-cycle latency via the FIFO as described above.

Decomposition:
- Shared branch package holds:
  - BrInstType_t (BR_BRANCH, BR_JUMP, BR_CALL, BR_RETURN);
  - BrUpdate_t packed struct {type, taken, miss, pc, tar};
  - defaults BtbDepth and UpdqDepth.
- One natural sub-module: br_upd_fifo, a synchronous FIFO of BrUpdate_t with full/empty, parameterised by depth.
- Arbitration and the INIT sweep stay in br_update_arb.

Test Plan:
- **Init sweep:** reset high 2 cycles, then low with BTB_DEPTH=8 → upd_inval=1 and upd_idx 0..7 on 8 consecutive cycles, init_done=1 from the 8th; com_stall falls the next cycle.
- **Basic commit:** com_valid, branch, pc=0x100, tar=0x180, taken=1 → next cycle upd_valid=1, upd_pc=0x100, upd_tar=0x180, upd_pred_en=1 (same cycle under BR_UPD_BYPASS_EN).
- **Full FIFO:** 5 back-to-back commits with UPDQ_DEPTH=4 and no drain possible → com_stall=1 after the 4th push; the 5th is held and later accepted; all 5 emerge in order.
- **Starvation:** dec_ins_req held while commits stream continuously with STARVE_LIM=3 → three commit grants, then dec_ins_ack=1 with upd_pred_en=0, then commits resume.
- **Flush:** dec_ins_req with an empty FIFO and flush=1 → dec_ins_ack=0 that cycle, ack=1 the following cycle.
- **Reset mid-operation:** reset while the FIFO holds 2 entries → FIFO empties, the sweep restarts at idx 0, and no stale entry is emitted after init_done.
